ps2_kb_rx: RTL and testbench

Synchronous, parametrised PS/2 keyboard receiver. It replaces the ps2c-clocked capture logic with a single-clock design that filters and synchronises the PS/2 lines, checks each frame, decodes E0/F0 prefixes, and tracks shift and caps-lock state. Complete key events are queued in a FIFO with a valid/ready handshake toward the terminal logic, which performs the ASCII translation downstream.

---
 rtl/ps2_kb_pkg.sv | 32 +++
 rtl/ps2_frame_rx.sv | 132 +++++++++++++
 rtl/ps2_kb_rx.sv | 158 +++++++++++++++
 tb/tb_ps2_kb_rx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ps2_kb_pkg.sv
// Shared constants, state encodings and the key event layout for the PS/2 keyboard receiver.
package ps2_kb_pkg;

    localparam logic [7:0] E0      = 8'hE0;
    localparam logic [7:0] BREAK   = 8'hF0;
    localparam logic [7:0] L_SHIFT = 8'h12;
    localparam logic [7:0] R_SHIFT = 8'h59;
    localparam logic [7:0] CAPS    = 8'h58;

    localparam int KD_BRK   = 11;
    localparam int KD_EXT   = 10;
    localparam int KD_SHIFT = 9;
    localparam int KD_CAPS  = 8;
    localparam int KD_W     = 12;

    typedef enum logic [1:0] {F_IDLE, F_DATA, F_PARITY, F_STOP} frame_state_t;
    typedef enum logic [1:0] {D_BASE, D_E0, D_F0, D_E0F0} dec_state_t;

    // Field order matches the KD_* positions above.
    typedef struct packed {
        logic       brk;
        logic       ext;
        logic       shift;
        logic       caps;
        logic [7:0] code;
    } key_event_t;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line front end: synchronisers, ps2c debounce, 11-bit frame FSM and inactivity timeout.
module ps2_frame_rx
    import ps2_kb_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_ps2c,
    input  logic       i_ps2d,
    output logic       o_frame_ok,
    output logic [7:0] o_byte,
    output logic       o_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_c_sync, r_d_sync;
    logic                   w_c_s, w_d_s;
    logic [FW-1:0]          r_flt_cnt;
    logic                   r_flt, r_fall;

    frame_state_t r_state, w_next;
    logic [7:0]   r_shift;
    logic [2:0]   r_bitcnt;
    logic         r_par;
    logic [TW-1:0] r_to_cnt;
    logic         w_timeout, w_frame_ok, w_err, w_stop_good;
    logic         r_frame_ok, r_err;
    logic [7:0]   r_byte;

    // Lines idle high, so synchronisers reset to 1 to avoid a spurious fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_c_sync <= '1;
            r_d_sync <= '1;
        end else begin
            r_c_sync <= {r_c_sync[SYNC_STAGES-2:0], i_ps2c};
            r_d_sync <= {r_d_sync[SYNC_STAGES-2:0], i_ps2d};
        end
    end

    assign w_c_s = r_c_sync[SYNC_STAGES-1];
    assign w_d_s = r_d_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flt     <= 1'b1;
            r_flt_cnt <= '0;
            r_fall    <= 1'b0;
        end else if (w_c_s != r_flt) begin
            if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
                r_flt     <= w_c_s;
                r_flt_cnt <= '0;
                r_fall    <= r_flt;
            end else begin
                r_flt_cnt <= r_flt_cnt + FW'(1);
                r_fall    <= 1'b0;
            end
        end else begin
            r_flt_cnt <= '0;
            r_fall    <= 1'b0;
        end
    end

    assign w_timeout   = (r_state != F_IDLE) && !r_fall && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign w_stop_good = w_d_s && odd_parity_ok(r_shift, r_par);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= F_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = F_IDLE;
        end else if (r_fall) begin
            case (r_state)
                F_IDLE:   if (!w_d_s) w_next = F_DATA;
                F_DATA:   if (r_bitcnt == 3'd7) w_next = F_PARITY;
                F_PARITY: w_next = F_STOP;
                F_STOP:   w_next = F_IDLE;
                default:  w_next = F_IDLE;
            endcase
        end
    end

    always_comb begin
        w_frame_ok = r_fall && (r_state == F_STOP) && w_stop_good;
        w_err      = w_timeout
                   || (r_fall && (r_state == F_IDLE) && w_d_s)
                   || (r_fall && (r_state == F_STOP) && !w_stop_good);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_par      <= 1'b0;
            r_to_cnt   <= '0;
            r_frame_ok <= 1'b0;
            r_err      <= 1'b0;
            r_byte     <= '0;
        end else begin
            if (r_fall) begin
                case (r_state)
                    F_IDLE:   r_bitcnt <= '0;
                    F_DATA: begin
                        r_shift  <= {w_d_s, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    F_PARITY: r_par <= w_d_s;
                    default:  ;
                endcase
            end
            if (r_state == F_IDLE || r_fall) r_to_cnt <= '0;
            else                             r_to_cnt <= r_to_cnt + TW'(1);
            r_frame_ok <= w_frame_ok;
            r_err      <= w_err;
            if (w_frame_ok) r_byte <= r_shift;
        end
    end

    assign o_frame_ok = r_frame_ok;
    assign o_byte     = r_byte;
    assign o_err      = r_err;

endmodule

// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver top: prefix decoder, shift/caps tracking and the key event FIFO.
module ps2_kb_rx
    import ps2_kb_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ps2c,
    input  logic            ps2d,
    output logic [KD_W-1:0] key_data,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            rx_err,
    output logic            overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic       w_frame_ok, w_err;
    logic [7:0] w_byte;

    dec_state_t r_dec, w_dec_next;
    logic       w_prefix, w_emit, w_brk, w_ext;
    logic       r_lshift, r_rshift, r_caps, r_caps_held;
    logic       w_lshift_n, w_rshift_n, w_caps_n, w_caps_held_n;
    key_event_t w_ev, r_ev;
    logic       r_push;

    key_event_t    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [AW:0]   r_count;
    logic          w_full, w_pop, w_wr_en;
    logic          r_overflow;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame (
        .clk       (clk),
        .reset     (reset),
        .i_ps2c    (ps2c),
        .i_ps2d    (ps2d),
        .o_frame_ok(w_frame_ok),
        .o_byte    (w_byte),
        .o_err     (w_err)
    );

    assign w_prefix = (w_byte == E0) || (w_byte == BREAK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_dec <= D_BASE;
        else       r_dec <= w_dec_next;
    end

    always_comb begin
        w_dec_next = r_dec;
        if (w_err) begin
            w_dec_next = D_BASE;
        end else if (w_frame_ok) begin
            if (w_byte == E0)
                w_dec_next = D_E0;
            else if (w_byte == BREAK)
                w_dec_next = (r_dec == D_E0 || r_dec == D_E0F0) ? D_E0F0 : D_F0;
            else
                w_dec_next = D_BASE;
        end
    end

    always_comb begin
        w_emit = w_frame_ok && !w_prefix;
        w_brk  = (r_dec == D_F0) || (r_dec == D_E0F0);
        w_ext  = (r_dec == D_E0) || (r_dec == D_E0F0);
    end

    // Modifiers are resolved combinationally so the event carries post-update state.
    always_comb begin
        w_lshift_n    = r_lshift;
        w_rshift_n    = r_rshift;
        w_caps_n      = r_caps;
        w_caps_held_n = r_caps_held;
        if (w_emit && !w_ext) begin
            case (w_byte)
                L_SHIFT: w_lshift_n = !w_brk;
                R_SHIFT: w_rshift_n = !w_brk;
                CAPS: begin
                    if (w_brk) begin
                        w_caps_held_n = 1'b0;
                    end else begin
                        if (!r_caps_held) w_caps_n = !r_caps;
                        w_caps_held_n = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        w_ev.brk   = w_brk;
        w_ev.ext   = w_ext;
        w_ev.shift = w_lshift_n | w_rshift_n;
        w_ev.caps  = w_caps_n;
        w_ev.code  = w_byte;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lshift    <= 1'b0;
            r_rshift    <= 1'b0;
            r_caps      <= 1'b0;
            r_caps_held <= 1'b0;
            r_push      <= 1'b0;
            r_ev        <= '0;
        end else begin
            r_lshift    <= w_lshift_n;
            r_rshift    <= w_rshift_n;
            r_caps      <= w_caps_n;
            r_caps_held <= w_caps_held_n;
            r_push      <= w_emit;
            if (w_emit) r_ev <= w_ev;
        end
    end

    assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
    assign w_pop   = key_valid && key_ready;
    assign w_wr_en = r_push && (!w_full || w_pop);

    // When full, a simultaneous pop frees the head slot that the push overwrites.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr] <= r_ev;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) r_rd <= r_rd + AW'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: ;
            endcase
            r_overflow <= r_push && w_full && !w_pop;
        end
    end

    assign key_data  = r_mem[r_rd];
    assign key_valid = (r_count != '0);
    assign rx_err    = w_err;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed bench for ps2_kb_rx: bit-banged PS/2 frames with hand-computed key events.
module tb_ps2_kb_rx;

    localparam int TO    = 1000;
    localparam int DEPTH = 8;

    logic        clk = 1'b0, reset = 1'b1, ps2c = 1'b1, ps2d = 1'b1, key_ready = 1'b0;
    logic [11:0] key_data;
    logic        key_valid, rx_err, overflow;

    int checks = 0, errors = 0;
    int err_hi = 0, err_pulses = 0, ovf_hi = 0, ovf_pulses = 0;
    logic err_prev = 1'b0, ovf_prev = 1'b0;

    ps2_kb_rx #(
        .SYNC_STAGES(2), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .ps2c(ps2c), .ps2d(ps2d),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .rx_err(rx_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_err) err_hi++;
        if (rx_err && !err_prev) err_pulses++;
        err_prev = rx_err;
        if (overflow) ovf_hi++;
        if (overflow && !ovf_prev) ovf_pulses++;
        ovf_prev = overflow;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        ps2d = b;
        repeat (10) @(negedge clk);
        ps2c = 1'b0;
        repeat (20) @(negedge clk);
        ps2c = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic flip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(~^b ^ flip);
        send_bit(1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic expect_entry(input string tag, input logic [11:0] exp);
        int n = 0;
        while (key_valid !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, key_valid, 1);
        chk(tag, key_data, exp);
        key_ready = 1'b1;
        @(negedge clk);
        key_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        int e0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", key_valid, 0);
        chk("rst_data", key_data, 0);
        chk("rst_err", rx_err, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 0x1C with latency check against the raw stop-bit fall
        b = 8'h1C;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(1'b0);
        ps2d = 1'b1;
        repeat (10) @(negedge clk);
        ps2c = 1'b0;
        repeat (8) @(posedge clk);
        #1 chk("lat_pre", key_valid, 0);
        @(posedge clk);
        #1 chk("lat_valid", key_valid, 1);
        chk("lat_data", key_data, 12'h01C);
        repeat (20) @(negedge clk);
        ps2c = 1'b1;
        repeat (20) @(negedge clk);
        expect_entry("e_1c", 12'h01C);
        chk("empty_1c", key_valid, 0);

        // Shift make/break sequence
        send_frame(8'h12, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        expect_entry("sh0", 12'h212);
        expect_entry("sh1", 12'h21C);
        expect_entry("sh2", 12'hA1C);
        expect_entry("sh3", 12'h812);
        chk("empty_sh", key_valid, 0);

        // Start bit high in IDLE
        e0 = err_pulses;
        send_bit(1'b1);
        repeat (10) @(negedge clk);
        chk("start_err", err_pulses, e0 + 1);

        // Parity error then a good frame
        send_frame(8'h1C, 1'b1);
        repeat (10) @(negedge clk);
        chk("par_err", err_pulses, e0 + 2);
        chk("par_noentry", key_valid, 0);
        send_frame(8'h1C, 1'b0);
        expect_entry("par_next", 12'h01C);

        // Partial frame abandoned by the timeout
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        repeat (TO + 100) @(negedge clk);
        chk("to_err", err_pulses, e0 + 3);
        chk("to_noentry", key_valid, 0);
        send_frame(8'h1C, 1'b0);
        expect_entry("to_next", 12'h01C);

        // Extended break, then caps with typematic repeat
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h75, 1'b0);
        expect_entry("ext_brk", 12'hC75);
        send_frame(8'h58, 1'b0);
        send_frame(8'h58, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h58, 1'b0);
        expect_entry("caps0", 12'h158);
        expect_entry("caps1", 12'h158);
        expect_entry("caps2", 12'h958);

        // Overflow: DEPTH+1 makes with no consumer; caps is still set
        for (int i = 0; i <= DEPTH; i++) send_frame(8'h15 + 8'(i), 1'b0);
        repeat (10) @(negedge clk);
        chk("ovf_pulses", ovf_pulses, 1);
        chk("ovf_width", ovf_hi, 1);
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'h15 + 8'(i);
            expect_entry("drain", {4'h1, b});
        end
        chk("empty_drain", key_valid, 0);

        // Reset in mid-frame, then a clean frame with modifiers cleared
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_valid", key_valid, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h1C, 1'b0);
        expect_entry("midrst_next", 12'h01C);

        chk("err_total", err_pulses, 3);
        chk("err_width", err_hi, err_pulses);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
